// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder.
// Holds the register byte addresses decoded from io_addr and the bit
// positions of the fields inside the OUT_STAT and IN_STAT status words.
package mmio_pkg;

  // Register byte addresses (low 8 bits of the CPU IO address).
  localparam logic [7:0] MMIO_LED      = 8'h00;
  localparam logic [7:0] MMIO_OUT_STAT = 8'h04;
  localparam logic [7:0] MMIO_OUT_DATA = 8'h08;
  localparam logic [7:0] MMIO_IN_STAT  = 8'h0C;
  localparam logic [7:0] MMIO_IN_DATA  = 8'h10;
  localparam logic [7:0] MMIO_SW_RAW   = 8'h14;

  // OUT_STAT fields.
  localparam int OUT_NOT_FULL_BIT = 0;
  localparam int OUT_EMPTY_BIT    = 1;
  localparam int OUT_OVF_BIT      = 2;
  localparam int OUT_COUNT_LSB    = 7;
  localparam int OUT_COUNT_W      = 8;

  // IN_STAT fields.
  localparam int IN_PENDING_BIT = 0;
  localparam int IN_OVERRUN_BIT = 1;

endpackage

// File: rtl/mmio_responder_if.sv
// CPU IO bus between the CPU (master) and an MMIO target (slave).
//   io_addr : register byte address (low 8 bits of the IO address)
//   io_dout : write data from the CPU
//   io_we   : one-cycle write strobe
//   io_rd   : one-cycle read strobe
//   io_din  : read data back to the CPU, combinational from io_addr
interface mmio_responder_if;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;

  modport master (output io_addr, io_dout, io_we, io_rd, input io_din);
  modport slave  (input io_addr, io_dout, io_we, io_rd, output io_din);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered storage array.
//   clk, rst : clock and synchronous active-high reset
//   push/din : write din when not full, or when full with a simultaneous pop
//   pop      : remove the head word (ignored when empty)
//   dout     : current head word
//   full, empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: every state element here uses non-blocking assignments so all
  // flops update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the storage array is reset because the head word is visible on
      // dout and must read as zero after reset; this only pays off for small
      // FIFOs like this one, larger ones should leave the array unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped IO responder at the target end of the CPU IO bus.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : CPU IO bus (slave side), zero-wait-state reads
//   sw, btn   : raw asynchronous switches and "input ready" button
//   led       : LED register
//   out_data, out_valid, out_ready : output FIFO head towards the sink
// Registers: LED (RW), OUT_STAT, OUT_DATA (push), IN_STAT, IN_DATA
// (read clears pending/overrun), SW_RAW. Unmapped reads return 0.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int SW_W       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mmio_responder_if.slave     bus,
  input  logic [SW_W-1:0]     sw,
  input  logic                btn,
  output logic [SW_W-1:0]     led,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SW_W-1:0] sw_s1, sw_s2;
  logic            btn_s1, btn_s2, btn_s3;
  logic            btn_edge;
  logic [SW_W-1:0] in_data;
  logic            pending;
  logic            overrun;
  logic            overflow;

  logic            wr_en, rd_en;
  logic            push, pop, rd_in_data, wr_out_stat, wr_led;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  // A write wins over a simultaneous read; the read's side effects are dropped.
  assign wr_en       = bus.io_we;
  assign rd_en       = bus.io_rd & ~bus.io_we;
  assign wr_led      = wr_en & (bus.io_addr == MMIO_LED);
  assign wr_out_stat = wr_en & (bus.io_addr == MMIO_OUT_STAT);
  assign push        = wr_en & (bus.io_addr == MMIO_OUT_DATA);
  assign rd_in_data  = rd_en & (bus.io_addr == MMIO_IN_DATA);
  assign pop         = out_valid & out_ready;
  assign out_valid   = ~fifo_empty;
  assign btn_edge    = btn_s2 & ~btn_s3;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.io_dout),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read mux: the CPU samples io_din in the same cycle as io_addr.
  always_comb begin
    // NOTE: default first so every path assigns io_din and no latch is inferred.
    bus.io_din = '0;
    case (bus.io_addr)
      MMIO_LED: bus.io_din = 32'(led);
      MMIO_OUT_STAT: begin
        bus.io_din[OUT_NOT_FULL_BIT]              = ~fifo_full;
        bus.io_din[OUT_EMPTY_BIT]                 = fifo_empty;
        bus.io_din[OUT_OVF_BIT]                   = overflow;
        bus.io_din[OUT_COUNT_LSB +: OUT_COUNT_W]  = OUT_COUNT_W'(fifo_count);
      end
      MMIO_IN_STAT: begin
        bus.io_din[IN_PENDING_BIT] = pending;
        bus.io_din[IN_OVERRUN_BIT] = overrun;
      end
      MMIO_IN_DATA: bus.io_din = 32'(in_data);
      MMIO_SW_RAW:  bus.io_din = 32'(sw_s2);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_s3   <= 1'b0;
      in_data  <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;

      if (wr_led) led <= bus.io_dout[SW_W-1:0];

      if (wr_out_stat)                       overflow <= 1'b0;
      else if (push && fifo_full && !pop)    overflow <= 1'b1;

      // An IN_DATA read consumes the held word; an edge in the same cycle
      // refills it immediately, so pending stays set and overrun is cleared.
      if (rd_in_data) begin
        overrun <= 1'b0;
        pending <= btn_edge;
        if (btn_edge) in_data <= sw_s2;
      end else if (btn_edge) begin
        if (!pending) begin
          in_data <= sw_s2;
          pending <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed steps followed by a
// randomized section, all checked against a behavioural model of the
// register map, the input channel (3-edge button latency) and the FIFO.
module tb_mmio_responder;

  localparam int SW_W  = 16;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic [SW_W-1:0] sw;
  logic            btn;
  logic [SW_W-1:0] led;
  logic [31:0]     out_data;
  logic            out_valid;
  logic            out_ready;

  mmio_responder_if bus ();

  mmio_responder #(.SW_W(SW_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sw        (sw),
    .btn       (btn),
    .led       (led),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [SW_W-1:0] m_led;
  logic [31:0]     m_q[$];
  bit              m_ovf;
  logic [SW_W-1:0] m_in;
  bit              m_pend;
  bit              m_ovr;
  // Inputs as sampled at the last three clock edges: [0] most recent.
  logic [SW_W-1:0] h_sw[3];
  bit              h_btn[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_din(input logic [7:0] a);
    int n;
    n = m_q.size();
    case (a)
      8'h00: return 32'(m_led);
      8'h04: return 32'(n) * 128 + (m_ovf ? 4 : 0) + (n == 0 ? 2 : 0) + (n < DEPTH ? 1 : 0);
      8'h0C: return (m_ovr ? 2 : 0) + (m_pend ? 1 : 0);
      8'h10: return 32'(m_in);
      8'h14: return 32'(h_sw[1]);
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_edge();
    bit rd_in, edge_now, popped;
    if (rst) begin
      m_led = '0; m_q.delete(); m_ovf = 0; m_in = '0; m_pend = 0; m_ovr = 0;
      for (int i = 0; i < 3; i++) begin h_sw[i] = '0; h_btn[i] = 0; end
      return;
    end
    // A button press is recognised three edges after it is first sampled.
    edge_now = h_btn[1] && !h_btn[2];
    rd_in    = bus.io_rd && !bus.io_we && bus.io_addr == 8'h10;
    if (rd_in) begin
      m_ovr = 0;
      if (edge_now) begin m_in = h_sw[1]; m_pend = 1; end
      else m_pend = 0;
    end else if (edge_now) begin
      if (!m_pend) begin m_in = h_sw[1]; m_pend = 1; end
      else m_ovr = 1;
    end
    popped = 0;
    if (m_q.size() > 0 && out_ready) begin void'(m_q.pop_front()); popped = 1; end
    if (bus.io_we && bus.io_addr == 8'h08) begin
      if (m_q.size() < DEPTH) m_q.push_back(bus.io_dout);
      else m_ovf = 1;
    end
    if (bus.io_we && bus.io_addr == 8'h04) m_ovf = 0;
    if (bus.io_we && bus.io_addr == 8'h00) m_led = bus.io_dout[SW_W-1:0];
    if (popped && m_q.size() > DEPTH) m_ovf = 1; // unreachable guard, keeps queue bounded
    h_sw[2] = h_sw[1]; h_sw[1] = h_sw[0]; h_sw[0] = sw;
    h_btn[2] = h_btn[1]; h_btn[1] = h_btn[0]; h_btn[0] = btn;
  endtask

  task automatic step();
    #1;
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
      check("led", 32'(led), 32'(m_led));
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.io_addr = a; bus.io_dout = d; bus.io_we = 1'b1;
    step();
    bus.io_we = 1'b0;
  endtask

  // Read with a fixed expected value written from the test plan.
  task automatic rd_exp(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.io_addr = a; bus.io_rd = 1'b1;
    #1;
    check(tag, bus.io_din, exp);
    step();
    bus.io_rd = 1'b0;
  endtask

  // Read checked against the model.
  task automatic rd_model(input string tag, input logic [7:0] a);
    bus.io_addr = a; bus.io_rd = 1'b1;
    #1;
    check(tag, bus.io_din, exp_din(a));
    step();
    bus.io_rd = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold sw stable, then present one clean button press.
  task automatic press(input logic [SW_W-1:0] v);
    sw = v; steps(2);
    btn = 1'b1; steps(3);
    btn = 1'b0; steps(3);
  endtask

  logic [7:0]  addr_tbl[9];
  logic [31:0] exp_seq[4];

  initial begin
    rst = 1'b1; sw = '0; btn = 1'b0; out_ready = 1'b0;
    bus.io_addr = '0; bus.io_dout = '0; bus.io_we = 1'b0; bus.io_rd = 1'b0;

    // Reset state.
    do_reset();
    chk_en = 1'b1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    rd_exp("rst_out_stat", 8'h04, 32'h3);
    rd_exp("rst_in_stat", 8'h0C, 32'h0);
    rd_exp("rst_sw_raw", 8'h14, 32'h0);

    // LED register and reset clearing it.
    wr(8'h00, 32'h0000A5A5);
    check("led_written", 32'(led), 32'h0000A5A5);
    rd_exp("led_read", 8'h00, 32'h0000A5A5);
    rd_exp("unmapped_read", 8'h18, 32'h0);
    do_reset();
    check("led_after_rst", 32'(led), 32'h0);

    // Button latency and IN_DATA read clearing pending.
    sw = 16'h1234; steps(2);
    btn = 1'b1; steps(2);
    rd_exp("pend_early", 8'h0C, 32'h0);
    rd_exp("pend_set", 8'h0C, 32'h1);
    btn = 1'b0;
    rd_exp("in_data_1234", 8'h10, 32'h00001234);
    rd_exp("pend_cleared", 8'h0C, 32'h0);

    // Two presses without a read: overrun, first word kept.
    press(16'h0011);
    press(16'h0022);
    rd_exp("overrun_stat", 8'h0C, 32'h3);
    rd_exp("overrun_data", 8'h10, 32'h00000011);
    rd_exp("overrun_cleared", 8'h0C, 32'h0);

    // FIFO overflow with the sink stalled.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) wr(8'h08, 32'(k));
    rd_exp("ovf_stat", 8'h04, 32'h204);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("drain_valid", 32'(out_valid), 32'h1);
      check("drain_data", out_data, 32'(k));
      step();
    end
    #1;
    check("drain_empty", 32'(out_valid), 32'h0);
    wr(8'h04, 32'h0);
    rd_exp("ovf_cleared", 8'h04, 32'h3);

    // Push into a full FIFO in the same cycle as a pop.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) wr(8'h08, 32'h10 + 32'(k));
    out_ready = 1'b1;
    wr(8'h08, 32'h9);
    out_ready = 1'b0;
    rd_exp("full_push_pop_stat", 8'h04, 32'h200);
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h12; exp_seq[2] = 32'h13; exp_seq[3] = 32'h9;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain2_data", out_data, exp_seq[k]);
      step();
    end
    #1;
    check("drain2_empty", 32'(out_valid), 32'h0);

    // Button edge coincident with an IN_DATA read.
    press(16'h0055);
    sw = 16'h0077; steps(2);
    btn = 1'b1; steps(2);
    rd_exp("coincident_old", 8'h10, 32'h00000055);
    btn = 1'b0;
    rd_exp("coincident_stat", 8'h0C, 32'h1);
    rd_exp("coincident_new", 8'h10, 32'h00000077);

    // Randomized traffic against the model.
    addr_tbl[0] = 8'h00; addr_tbl[1] = 8'h04; addr_tbl[2] = 8'h08;
    addr_tbl[3] = 8'h0C; addr_tbl[4] = 8'h10; addr_tbl[5] = 8'h14;
    addr_tbl[6] = 8'h18; addr_tbl[7] = 8'hFF; addr_tbl[8] = 8'h01;
    for (int it = 0; it < 600; it++) begin
      sw = SW_W'($urandom);
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      out_ready = 1'($urandom);
      case ($urandom_range(0, 6))
        0: wr(8'h00, $urandom);
        1, 2: wr(8'h08, $urandom);
        3: rd_model("rand_rd", addr_tbl[$urandom_range(0, 8)]);
        4: if ($urandom_range(0, 3) == 0) wr(8'h04, $urandom); else step();
        5: begin
          bus.io_addr = 8'h10; bus.io_dout = $urandom;
          bus.io_we = 1'b1; bus.io_rd = 1'b1;
          #1;
          check("we_rd_din", bus.io_din, exp_din(8'h10));
          step();
          bus.io_we = 1'b0; bus.io_rd = 1'b0;
        end
        default: if ($urandom_range(0, 49) == 0) do_reset(); else step();
      endcase
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) rd_model("final_rd", addr_tbl[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped IO responder on the CPU's IO bus: the target end of io_addr/io_dout/io_we/io_rd/io_din, selected by the CPU for byte addresses 0xFF00-0xFFFF, addressed by the low 8 bits.
- Provides an LED register, a button-qualified switch input channel with a pending flag, and a buffered output channel (FIFO) draining to a display/console sink via valid/ready.

Parameters:
SW_W, 16, width of switch input and LED register (1..32)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
io_addr  input  8  register byte address
io_dout  input  32  write data from CPU
io_we  input  1  write strobe, one cycle per store
io_rd  input  1  read strobe, one cycle per load
io_din  output  32  read data to CPU, combinational from io_addr
sw  input  SW_W  raw switches (asynchronous)
btn  input  1  raw "input ready" button (asynchronous, debounced externally)
led  output  SW_W  LED register
out_data  output  32  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  sink accepts head this cycle

Behaviour:
- Clocking/reset: one clock domain; reset is synchronous and active-high. All state cleared on rst=1 at a clk edge: led=0, in_data=0, pending=0, overrun=0, overflow=0, FIFO empty (out_valid=0, out_data=0), synchronizer flops=0. Reset mid-transfer discards FIFO contents and pending input.
- Register map (io_addr), unmapped reads return 0, unmapped writes ignored:
  - 0x00 LED: RW; write stores io_dout[SW_W-1:0]; read zero-extends.
  - 0x04 OUT_STAT: R: bit0 = not full, bit1 = empty, bit2 = overflow sticky, bits[7+:8] = count. Any write clears overflow.
  - 0x08 OUT_DATA: W: push io_dout. Read returns 0.
  - 0x0C IN_STAT: R: bit0 = pending, bit1 = overrun sticky.
  - 0x10 IN_DATA: R: zero-extended in_data; read (io_rd=1) clears pending and overrun at the edge.
  - 0x14 SW_RAW: R: synchronized sw, no side effect.
- Read path: io_din is combinational from io_addr and current state (zero wait states). The CPU samples it in the same cycle. Side effects apply only when io_rd=1 and take effect at that clock edge.
- Input channel:
  - sw and btn pass through 2-flop synchronizers; btn has a third flop for rising-edge detection. Latency from btn rise to pending=1 is 3 cycles.
  - On an edge with pending=0: in_data<=sync sw, pending<=1.
  - On an edge with pending=1: data kept, overrun<=1.
  - Simultaneous IN_DATA read and edge: io_din returns the old data, in_data<=new sw, pending stays 1, overrun cleared.
- Output FIFO:
  - push = io_we & addr==0x08.
  - pop = out_valid & out_ready.
  - out_data is the registered head, valid whenever out_valid=1.
  - Push when full with no pop: word dropped, overflow<=1.
  - Push when full with a simultaneous pop: accepted, count unchanged.
  - Push when empty: out_valid=1 the next cycle (1-cycle latency).
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- io_we and io_rd never occur together. If both are asserted, the write executes and the read's side effects are suppressed.

Decomposition:
- Shared package mmio_pkg: address constants (MMIO_LED=8'h00, MMIO_OUT_STAT=8'h04, MMIO_OUT_DATA=8'h08, MMIO_IN_STAT=8'h0C, MMIO_IN_DATA=8'h10, MMIO_SW_RAW=8'h14) and status bit indices.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), with ports push/pop/din/dout/full/empty/count. The responder owns the overflow flag.

Test Plan:
- Reset then write 0x0000A5A5 to 0x00 -> led=16'hA5A5 next cycle; read 0x00 returns 0x0000A5A5; rst=1 -> led=0.
- sw=16'h1234, pulse btn -> pending=1 after 3 cycles; read 0x0C -> 1; read 0x10 -> 0x00001234 and pending=0 next cycle.
- Two btn edges without a read (sw=0x11 then 0x22) -> read 0x0C returns 3 (pending+overrun); read 0x10 returns 0x11; 0x0C then returns 0.
- out_ready=0, push 5 words (1..5) with FIFO_DEPTH=4 -> 0x04 reads count=4, overflow=1, not-full=0; raise out_ready -> sink receives 1,2,3,4 in order, one per cycle; out_valid=0 after.
- FIFO full, push 9 in the same cycle as a pop -> accepted, overflow unchanged; drained sequence ends with 9.
- Edge coincident with an IN_DATA read (sw=0x77, old data 0x55) -> io_din=0x55, pending stays 1, next IN_DATA read returns 0x77.
